conv_engine: RTL and testbench

Self-contained 2-D convolution engine: loads a K×K unsigned filter and a K-row image strip from word-wide memory, slides the filter horizontally across the strip, and writes packed results back to memory. It is the parametrised successor of the fixed 8-bit/4×4 convolution datapath. Data width, filter size and strip length are generalised, and the address generation, sequencing FSM and output packing live inside the block. It sits between the top-level controller (start/done handshake) and the shared synchronous memory.

---
 rtl/conv_engine_if.sv | 15 +
 rtl/conv_engine.sv | 190 +++++++++++++++++++
 tb/tb_conv_engine.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/conv_engine_if.sv
// Word-wide synchronous memory port between conv_engine (master) and the shared memory.
interface conv_engine_if #(
  parameter int ADDR_W = 8,
  parameter int WORD_W = 32
);
  logic              mem_re;
  logic [ADDR_W-1:0] mem_raddr;
  logic [WORD_W-1:0] mem_rdata;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [WORD_W-1:0] mem_wdata;

  modport master (output mem_re, mem_raddr, mem_we, mem_waddr, mem_wdata, input mem_rdata);
  modport slave  (input mem_re, mem_raddr, mem_we, mem_waddr, mem_wdata, output mem_rdata);
endinterface

// File: rtl/conv_engine.sv
// K x K convolution engine: loads filter and K-row strip, slides horizontally, packs results.
// Define CONV_SAT_EN to saturate results to DATA_W bits instead of truncating.
module conv_lane #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0]   px,
  input  logic [DATA_W-1:0]   cf,
  output logic [2*DATA_W-1:0] prod
);
  assign prod = (2*DATA_W)'(px) * (2*DATA_W)'(cf);
endmodule

module conv_engine #(
  parameter int DATA_W    = 8,
  parameter int LANES     = 4,
  parameter int IMG_WORDS = 4,
  parameter int ADDR_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] filt_base,
  input  logic [ADDR_W-1:0] img_base,
  input  logic [ADDR_W-1:0] out_base,
  output logic              busy,
  output logic              done,
  conv_engine_if.master     bus
);
  localparam int K      = LANES;
  localparam int WORD_W = DATA_W * LANES;
  localparam int P      = IMG_WORDS * LANES;
  localparam int NOUT   = P - K + 1;
  localparam int NWORDS = (NOUT + LANES - 1) / LANES;
  localparam int NIMG   = K * IMG_WORDS;
  localparam int ACC_W  = 2*DATA_W + 2*$clog2(K);
  localparam int CW     = $clog2(NIMG + 1);
  localparam int IXW    = (NIMG > 1) ? $clog2(NIMG) : 1;
  localparam int RW     = $clog2(K);
  localparam int XW     = $clog2(P);
  localparam int PW     = (NOUT > 1) ? $clog2(NOUT) : 1;
  localparam int WW     = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  typedef enum logic [2:0] {S_IDLE, S_LD_FILT, S_LD_IMG, S_MAC, S_WRITE, S_DONE} state_t;
  state_t state, nxt;

  logic [ADDR_W-1:0]               fbase, ibase, obase;
  logic [CW-1:0]                   idx;
  logic [IXW-1:0]                  cap_idx;
  logic                            issue, cap_vld, cap_img;
  logic [K-1:0][K-1:0][DATA_W-1:0] filt;
  logic [NIMG-1:0][WORD_W-1:0]     img_w;
  logic [K-1:0][P-1:0][DATA_W-1:0] img_px;
  logic [RW-1:0]                   row, ln;
  logic [PW-1:0]                   p;
  logic [WW-1:0]                   wn;
  logic [ACC_W-1:0]                acc, dot, acc_sum;
  logic [K-1:0][2*DATA_W-1:0]      prod;
  logic [LANES-1:0][DATA_W-1:0]    pack;
  logic [DATA_W-1:0]               res;
  logic                            last_row, last_p, pack_full;

  // Row-major word storage reinterpreted as per-row pixel arrays.
  assign img_px = img_w;

  for (genvar c = 0; c < K; c++) begin : g_lane
    logic [XW-1:0] col;
    assign col = XW'(p) + XW'(c);
    conv_lane #(.DATA_W(DATA_W)) u_lane (
      .px(img_px[row][col]), .cf(filt[row][c]), .prod(prod[c])
    );
  end

  always_comb begin
    dot = '0;
    for (int c = 0; c < K; c++) dot = dot + ACC_W'(prod[c]);
  end

  assign acc_sum = ((row == '0) ? '0 : acc) + dot;

`ifdef CONV_SAT_EN
  assign res = (|acc_sum[ACC_W-1:DATA_W]) ? '1 : acc_sum[DATA_W-1:0];
`else
  assign res = acc_sum[DATA_W-1:0];
`endif

  assign last_row  = (row == RW'(K-1));
  assign last_p    = (p == PW'(NOUT-1));
  assign pack_full = (ln == RW'(LANES-1));

  always_comb begin
    nxt   = state;
    issue = 1'b0;
    case (state)
      S_IDLE:    if (start) nxt = S_LD_FILT;
      S_LD_FILT: begin
        issue = (idx < CW'(K));
        if (idx == CW'(K)) nxt = S_LD_IMG;
      end
      S_LD_IMG:  begin
        issue = (idx < CW'(NIMG));
        if (idx == CW'(NIMG)) nxt = S_MAC;
      end
      S_MAC:     if (last_row && (pack_full || last_p)) nxt = S_WRITE;
      S_WRITE:   nxt = last_p ? S_DONE : S_MAC;
      S_DONE:    nxt = S_IDLE;
      default:   nxt = S_IDLE;
    endcase
  end

  // Strobes decode straight from state so a reset drops them without waiting for a clock.
  assign busy          = (state != S_IDLE);
  assign done          = (state == S_DONE);
  assign bus.mem_re    = issue;
  assign bus.mem_raddr = ((state == S_LD_IMG) ? ibase : fbase) + ADDR_W'(idx);
  assign bus.mem_we    = (state == S_WRITE);
  assign bus.mem_waddr = obase + ADDR_W'(wn);
  assign bus.mem_wdata = pack;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      fbase   <= '0;
      ibase   <= '0;
      obase   <= '0;
      idx     <= '0;
      cap_idx <= '0;
      cap_vld <= 1'b0;
      cap_img <= 1'b0;
      filt    <= '0;
      img_w   <= '0;
      row     <= '0;
      p       <= '0;
      ln      <= '0;
      wn      <= '0;
      acc     <= '0;
      pack    <= '0;
    end else begin
      state   <= nxt;
      cap_vld <= issue;
      cap_img <= (state == S_LD_IMG);
      cap_idx <= idx[IXW-1:0];
      if (cap_vld) begin
        if (cap_img) img_w[cap_idx] <= bus.mem_rdata;
        else         filt[cap_idx[RW-1:0]] <= bus.mem_rdata;
      end
      case (state)
        S_IDLE: begin
          idx <= '0;
          if (start) begin
            fbase <= filt_base;
            ibase <= img_base;
            obase <= out_base;
          end
        end
        S_LD_FILT: idx <= (idx == CW'(K)) ? '0 : idx + CW'(1);
        S_LD_IMG: begin
          idx <= idx + CW'(1);
          if (idx == CW'(NIMG)) begin
            idx  <= '0;
            row  <= '0;
            p    <= '0;
            ln   <= '0;
            wn   <= '0;
            pack <= '0;
          end
        end
        S_MAC: begin
          acc <= acc_sum;
          row <= row + RW'(1);
          if (last_row) begin
            row      <= '0;
            pack[ln] <= res;
            // A full pack or the final output advances p from WRITE instead.
            if (!pack_full && !last_p) begin
              p  <= p + PW'(1);
              ln <= ln + RW'(1);
            end
          end
        end
        S_WRITE: begin
          pack <= '0;
          wn   <= wn + WW'(1);
          ln   <= '0;
          if (!last_p) p <= p + PW'(1);
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_conv_engine.sv
// Directed bench for conv_engine: table of full jobs plus abort, restart and single-output sequences.
module tb_conv_engine;
  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start0, start1, busy0, done0, busy1, done1;
  logic [7:0] fb, ib, ob;
  logic       ld_we, ld_sel;
  logic [7:0] ld_addr;
  logic [31:0] ld_data;

  conv_engine_if #(.ADDR_W(8), .WORD_W(32)) b0 ();
  conv_engine_if #(.ADDR_W(8), .WORD_W(32)) b1 ();

  conv_engine #(.DATA_W(8), .LANES(4), .IMG_WORDS(4), .ADDR_W(8)) u0 (
    .clk(clk), .rst(rst), .start(start0), .filt_base(fb), .img_base(ib), .out_base(ob),
    .busy(busy0), .done(done0), .bus(b0)
  );
  conv_engine #(.DATA_W(8), .LANES(4), .IMG_WORDS(1), .ADDR_W(8)) u1 (
    .clk(clk), .rst(rst), .start(start1), .filt_base(fb), .img_base(ib), .out_base(ob),
    .busy(busy1), .done(done1), .bus(b1)
  );

  logic [31:0] mem0 [256];
  logic [31:0] mem1 [256];
  int wr0 = 0, wr1 = 0, dn0 = 0;

  always @(posedge clk) begin
    if (b0.mem_re) b0.mem_rdata <= mem0[b0.mem_raddr];
    if (b0.mem_we) begin mem0[b0.mem_waddr] <= b0.mem_wdata; wr0 <= wr0 + 1; end
    if (ld_we && !ld_sel) mem0[ld_addr] <= ld_data;
    if (done0) dn0 <= dn0 + 1;
  end

  always @(posedge clk) begin
    if (b1.mem_re) b1.mem_rdata <= mem1[b1.mem_raddr];
    if (b1.mem_we) begin mem1[b1.mem_waddr] <= b1.mem_wdata; wr1 <= wr1 + 1; end
    if (ld_we && ld_sel) mem1[ld_addr] <= ld_data;
  end

  typedef struct packed {
    logic            fm;   // 1: identity-diagonal filter, 0: constant fv
    logic [7:0]      fv, rk, fb, ib, ob;
    logic [3:0][31:0] exp;
  } vec_t;

  vec_t vecs [5];
  int n_cmp = 0, n_bad = 0;

  function automatic vec_t mkv(input logic fm, input logic [7:0] fv, rk, vfb, vib, vob,
                               input logic [31:0] w0, w1, w2, w3);
    vec_t v;
    v.fm = fm; v.fv = fv; v.rk = rk; v.fb = vfb; v.ib = vib; v.ob = vob;
    v.exp = {w3, w2, w1, w0};
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
    end
  endtask

  task automatic wr_mem(input bit sel, input logic [7:0] a, input logic [31:0] d);
    ld_sel = sel; ld_addr = a; ld_data = d; ld_we = 1'b1;
    @(negedge clk);
    ld_we = 1'b0;
  endtask

  // Image pixel at row r, column x is rk*r + x.
  task automatic setup(input bit sel, input vec_t v, input int iw);
    logic [31:0] d;
    for (int n = 0; n < 4; n++) wr_mem(sel, v.ob + 8'(n), 32'hA5A5A5A5);
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) d[c*8 +: 8] = v.fm ? ((r == c) ? 8'd1 : 8'd0) : v.fv;
      wr_mem(sel, v.fb + 8'(r), d);
    end
    for (int r = 0; r < 4; r++)
      for (int w = 0; w < iw; w++) begin
        for (int l = 0; l < 4; l++) d[l*8 +: 8] = 8'(int'(v.rk) * r + w*4 + l);
        wr_mem(sel, v.ib + 8'(r*iw + w), d);
      end
  endtask

  task automatic start_job(input bit sel, input vec_t v);
    fb = v.fb; ib = v.ib; ob = v.ob;
    if (sel) start1 = 1'b1; else start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0; start1 = 1'b0;
  endtask

  // Entered in the first cycle after the accepting edge (cycle t+1).
  task automatic wait_done(input bit sel, output int cyc);
    cyc = 1;
    while (!(sel ? done1 : done0) && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic chk_words(input bit sel, input vec_t v, input int nw, input string tag);
    logic [7:0] a;
    for (int n = 0; n < nw; n++) begin
      a = v.ob + 8'(n);
      chk($sformatf("%s_w%0d", tag, n), sel ? mem1[a] : mem0[a], v.exp[n]);
    end
  endtask

  task automatic run_vec(input int i);
    int cyc, w;
    setup(1'b0, vecs[i], 4);
    w = wr0;
    start_job(1'b0, vecs[i]);
    wait_done(1'b0, cyc);
    chk($sformatf("v%0d_done_cyc", i), cyc, 79);
    @(negedge clk);
    chk($sformatf("v%0d_busy_after", i), busy0, 0);
    chk_words(1'b0, vecs[i], 4, $sformatf("v%0d", i));
    chk($sformatf("v%0d_writes", i), wr0 - w, 4);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, w, d;
    vec_t v1;
    rst = 1'b0; start0 = 1'b0; start1 = 1'b0; fb = '0; ib = '0; ob = '0;
    ld_we = 1'b0; ld_sel = 1'b0; ld_addr = '0; ld_data = '0;

    // outputs 16p+24 for the ones filter over a column-index image
    vecs[0] = mkv(1'b0, 8'd1, 8'd0, 8'h00, 8'h10, 8'h40,
                  32'h48382818, 32'h88786858, 32'hC8B8A898, 32'h000000D8);
`ifdef CONV_SAT_EN
    vecs[1] = mkv(1'b0, 8'd2, 8'd0, 8'h00, 8'h10, 8'h40,
                  32'h90705030, 32'hFFF0D0B0, 32'hFFFFFFFF, 32'h000000FF);
`else
    vecs[1] = mkv(1'b0, 8'd2, 8'd0, 8'h00, 8'h10, 8'h40,
                  32'h90705030, 32'h10F0D0B0, 32'h90705030, 32'h000000B0);
`endif
    vecs[2] = mkv(1'b0, 8'd1, 8'd0, 8'h20, 8'h10, 8'hFE,
                  32'h48382818, 32'h88786858, 32'hC8B8A898, 32'h000000D8);
    vecs[3] = mkv(1'b0, 8'd1, 8'd0, 8'h20, 8'hF8, 8'h40,
                  32'h48382818, 32'h88786858, 32'hC8B8A898, 32'h000000D8);
    // diagonal filter, pixel = 16r + x: outputs 4p+102
    vecs[4] = mkv(1'b1, 8'd0, 8'd16, 8'h30, 8'h80, 8'h60,
                  32'h726E6A66, 32'h827E7A76, 32'h928E8A86, 32'h00000096);

    repeat (2) @(negedge clk);
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    chk("rst_mem_re", b0.mem_re, 0);
    chk("rst_mem_we", b0.mem_we, 0);
    chk("rst_raddr", b0.mem_raddr, 0);
    chk("rst_waddr", b0.mem_waddr, 0);
    chk("rst_wdata", b0.mem_wdata, 0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++) run_vec(i);

    // reset in the middle of MAC aborts the job
    setup(1'b0, vecs[0], 4);
    start_job(1'b0, vecs[0]);
    for (int k = 1; k < 40; k++) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_busy", busy0, 0);
    chk("abort_mem_we", b0.mem_we, 0);
    chk("abort_mem_re", b0.mem_re, 0);
    d = dn0;
    @(negedge clk);
    rst = 1'b1;
    repeat (100) @(negedge clk);
    chk("abort_no_done", dn0 - d, 0);
    chk("abort_idle", busy0, 0);
    run_vec(0);

    // start while busy is dropped; start held over DONE is taken in the first IDLE cycle
    setup(1'b0, vecs[0], 4);
    w = wr0;
    start_job(1'b0, vecs[0]);
    cyc = 1;
    while (!done0 && cyc < 300) begin
      start0 = (cyc == 10);
      @(negedge clk);
      cyc++;
    end
    chk("rs_done_cyc1", cyc, 79);
    start0 = 1'b1;
    @(negedge clk);
    chk("rs_idle_busy", busy0, 0);
    @(negedge clk);
    start0 = 1'b0;
    chk("rs_restart_busy", busy0, 1);
    wait_done(1'b0, cyc);
    chk("rs_done_cyc2", cyc, 79);
    @(negedge clk);
    chk_words(1'b0, vecs[0], 4, "rs");
    chk("rs_writes", wr0 - w, 8);

    // single-word rows: one output, one write
    v1 = mkv(1'b0, 8'd1, 8'd0, 8'h00, 8'h10, 8'h40, 32'h00000018, 32'h0, 32'h0, 32'h0);
    setup(1'b1, v1, 1);
    w = wr1;
    start_job(1'b1, v1);
    wait_done(1'b1, cyc);
    chk("iw1_done_cyc", cyc, 16);
    @(negedge clk);
    chk("iw1_busy_after", busy1, 0);
    chk_words(1'b1, v1, 1, "iw1");
    chk("iw1_writes", wr1 - w, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
